// File: rtl/his_bank_scheduler.sv
// ---------------------------------------------------------------------------
// his_bank_scheduler
//
// Ping-pong scheduler for a two-bank TDC histogram RAM. One bank is cleared
// and then accumulates TDC samples while the other bank waits to be read out
// by a consumer. When the accumulating bank has seen every sample of every
// pixel for ACQ_NUM acquisitions it is handed to the reader, and the banks
// swap once the reader has released the previous one.
//
// Ports
//   i_clk         : clock, everything on the rising edge
//   i_res         : synchronous active-high reset
//   i_tdc_valid   : TDC sample present
//   i_tdc_addr    : bin index of the sample
//   o_tdc_ready   : sample accepted this cycle when i_tdc_valid is high
//   o_wr_en       : increment command to histogram RAM
//   o_wr_bank     : bank of the increment
//   o_wr_addr     : address of the increment (pixel*BIN_NUM + bin)
//   o_clr_en      : zero-write command to histogram RAM
//   o_clr_bank    : bank being cleared
//   o_clr_addr    : address being cleared
//   o_rd_req      : a completed bank is waiting for readout
//   o_rd_bank     : bank waiting for readout
//   i_rd_done     : pulse from the reader, readout of o_rd_bank finished
//   o_active_bank : bank currently being cleared/accumulated
//   o_his_done    : one-cycle pulse when a histogram completes
// ---------------------------------------------------------------------------
module his_bank_scheduler #(
    parameter int NB        = 8,
    parameter int DATA_NUM  = 2,
    parameter int PIXEL_NUM = 200,
    parameter int ACQ_NUM   = 33333,
    localparam int BIN_NUM   = 2**NB,
    localparam int RAM_DEPTH = PIXEL_NUM * BIN_NUM,
    localparam int AW        = $clog2(RAM_DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_res,
    input  logic          i_tdc_valid,
    input  logic [NB-1:0] i_tdc_addr,
    output logic          o_tdc_ready,
    output logic          o_wr_en,
    output logic          o_wr_bank,
    output logic [AW-1:0] o_wr_addr,
    output logic          o_clr_en,
    output logic          o_clr_bank,
    output logic [AW-1:0] o_clr_addr,
    output logic          o_rd_req,
    output logic          o_rd_bank,
    input  logic          i_rd_done,
    output logic          o_active_bank,
    output logic          o_his_done
);

    localparam int IW = (DATA_NUM  > 1) ? $clog2(DATA_NUM)  : 1;
    localparam int PW = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;
    localparam int QW = (ACQ_NUM   > 1) ? $clog2(ACQ_NUM)   : 1;

    typedef enum logic [1:0] {
        CLEAR,
        ACCUM,
        WAIT,
        SWAP
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [IW-1:0] r_input_count;
    logic [PW-1:0] r_pixel_count;
    logic [QW-1:0] r_acq_count;
    logic          r_wr_en;
    logic          r_wr_bank;
    logic [AW-1:0] r_wr_addr;
    logic          r_clr_en;
    logic [AW-1:0] r_clr_addr;
    logic          r_rd_req;
    logic          r_rd_bank;
    logic          r_rd_pending;
    logic          r_active_bank;
    logic          r_his_done;

    logic          w_accept;
    logic          w_input_last;
    logic          w_pixel_last;
    logic          w_acq_last;
    logic          w_bank_full;
    logic          w_rd_ack;
    logic          w_clr_last;
    logic [AW-1:0] w_wr_addr;

    assign w_accept     = i_tdc_valid && (r_state == ACCUM);
    assign w_input_last = (r_input_count == IW'(DATA_NUM - 1));
    assign w_pixel_last = (r_pixel_count == PW'(PIXEL_NUM - 1));
    assign w_acq_last   = (r_acq_count   == QW'(ACQ_NUM - 1));
    assign w_bank_full  = w_accept && w_input_last && w_pixel_last && w_acq_last;
    // A done pulse only counts while a readout is actually outstanding.
    assign w_rd_ack     = i_rd_done && r_rd_req;
    assign w_clr_last   = r_clr_en && (r_clr_addr == AW'(RAM_DEPTH - 1));
    // BIN_NUM is a power of two, so pixel*BIN_NUM + bin is a concatenation.
    assign w_wr_addr    = AW'({r_pixel_count, i_tdc_addr});

    // Next-state logic of the bank FSM.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CLEAR:   if (w_clr_last) w_state_next = ACCUM;
            ACCUM:   if (w_bank_full) w_state_next = WAIT;
            WAIT:    if (!r_rd_pending || w_rd_ack) w_state_next = SWAP;
            SWAP:    w_state_next = CLEAR;
            default: w_state_next = CLEAR;
        endcase
    end

    // State register, sample counters and registered RAM/readout commands.
    // The clear sweep is launched directly from SWAP so that the first
    // zero-write of the new bank appears together with the bank flip.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_state       <= CLEAR;
            r_input_count <= '0;
            r_pixel_count <= '0;
            r_acq_count   <= '0;
            r_wr_en       <= 1'b0;
            r_wr_bank     <= 1'b0;
            r_wr_addr     <= '0;
            r_clr_en      <= 1'b0;
            r_clr_addr    <= '0;
            r_rd_req      <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_rd_pending  <= 1'b0;
            r_active_bank <= 1'b0;
            r_his_done    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wr_en    <= w_accept;
            r_his_done <= w_bank_full;

            if (w_accept) begin
                r_wr_addr <= w_wr_addr;
                r_wr_bank <= r_active_bank;
                if (!w_input_last) begin
                    r_input_count <= r_input_count + 1'b1;
                end else begin
                    r_input_count <= '0;
                    if (!w_pixel_last) begin
                        r_pixel_count <= r_pixel_count + 1'b1;
                    end else begin
                        r_pixel_count <= '0;
                        if (!w_acq_last) r_acq_count <= r_acq_count + 1'b1;
                        else             r_acq_count <= '0;
                    end
                end
            end

            r_clr_en <= (r_state == SWAP) || ((r_state == CLEAR) && !w_clr_last);
            if ((r_state == CLEAR) && r_clr_en && !w_clr_last)
                r_clr_addr <= r_clr_addr + 1'b1;
            else
                r_clr_addr <= '0;

            // SWAP wins over an acknowledge landing in the same cycle.
            if (r_state == SWAP) begin
                r_rd_req      <= 1'b1;
                r_rd_pending  <= 1'b1;
                r_rd_bank     <= r_active_bank;
                r_active_bank <= ~r_active_bank;
            end else if (w_rd_ack) begin
                r_rd_req     <= 1'b0;
                r_rd_pending <= 1'b0;
            end
        end
    end

    assign o_tdc_ready   = (r_state == ACCUM);
    assign o_wr_en       = r_wr_en;
    assign o_wr_bank     = r_wr_bank;
    assign o_wr_addr     = r_wr_addr;
    assign o_clr_en      = r_clr_en;
    assign o_clr_bank    = r_active_bank;
    assign o_clr_addr    = r_clr_addr;
    assign o_rd_req      = r_rd_req;
    assign o_rd_bank     = r_rd_bank;
    assign o_active_bank = r_active_bank;
    assign o_his_done    = r_his_done;

endmodule

// File: tb/tb_his_bank_scheduler.sv
// ---------------------------------------------------------------------------
// tb_his_bank_scheduler
//
// Self-checking bench for his_bank_scheduler with a small configuration
// (4 bins, 2 samples per pixel, 2 pixels, 2 acquisitions, 8 RAM words).
// A vector table walks reset, the first clear, the first bank fill and the
// first swap; hand-written sequences then cover waiting for the reader,
// readout release, reset in the middle of a fill and stray rd_done pulses.
// ---------------------------------------------------------------------------
module tb_his_bank_scheduler;

    logic       clk;
    logic       res;
    logic       tdcValid;
    logic [1:0] tdcAddr;
    logic       tdcReady;
    logic       wrEn;
    logic       wrBank;
    logic [2:0] wrAddr;
    logic       clrEn;
    logic       clrBank;
    logic [2:0] clrAddr;
    logic       rdReq;
    logic       rdBank;
    logic       rdDone;
    logic       activeBank;
    logic       hisDone;

    int compared = 0;
    int mismatched = 0;

    his_bank_scheduler #(
        .NB        (2),
        .DATA_NUM  (2),
        .PIXEL_NUM (2),
        .ACQ_NUM   (2)
    ) dut (
        .i_clk         (clk),
        .i_res         (res),
        .i_tdc_valid   (tdcValid),
        .i_tdc_addr    (tdcAddr),
        .o_tdc_ready   (tdcReady),
        .o_wr_en       (wrEn),
        .o_wr_bank     (wrBank),
        .o_wr_addr     (wrAddr),
        .o_clr_en      (clrEn),
        .o_clr_bank    (clrBank),
        .o_clr_addr    (clrAddr),
        .o_rd_req      (rdReq),
        .o_rd_bank     (rdBank),
        .i_rd_done     (rdDone),
        .o_active_bank (activeBank),
        .o_his_done    (hisDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       res;
        logic       valid;
        logic [1:0] addr;
        logic       rdDone;
        logic       rdy;
        logic       wrEn;
        logic       wrBank;
        logic [2:0] wrAddr;
        logic       clrEn;
        logic       clrBank;
        logic [2:0] clrAddr;
        logic       rdReq;
        logic       rdBank;
        logic       act;
        logic       his;
        logic       chkAll;
    } vec_t;

    vec_t vecs[$];

    // Bit layout: rdy wrEn wrBank wrAddr[3] clrEn clrBank clrAddr[3] rdReq rdBank act his
    function automatic logic [14:0] packOut(input logic rdy, input logic we, input logic wb,
                                            input logic [2:0] wa, input logic ce, input logic cb,
                                            input logic [2:0] ca, input logic rq, input logic rb,
                                            input logic ab, input logic hd);
        return {rdy, we, wb, wa, ce, cb, ca, rq, rb, ab, hd};
    endfunction

    task automatic addVec(input logic r, input logic v, input logic [1:0] a, input logic d,
                          input logic rdy, input logic we, input logic wb, input logic [2:0] wa,
                          input logic ce, input logic cb, input logic [2:0] ca,
                          input logic rq, input logic rb, input logic ab, input logic hd,
                          input logic all);
        vec_t x;
        x.res = r;   x.valid = v;  x.addr = a;     x.rdDone = d;
        x.rdy = rdy; x.wrEn = we;  x.wrBank = wb;  x.wrAddr = wa;
        x.clrEn = ce; x.clrBank = cb; x.clrAddr = ca;
        x.rdReq = rq; x.rdBank = rb; x.act = ab;   x.his = hd;
        x.chkAll = all;
        vecs.push_back(x);
    endtask

    // Drive inputs just after a rising edge, then advance to just after the next one.
    task automatic applyStimulus(input logic r, input logic v, input logic [1:0] a, input logic d);
        res = r;
        tdcValid = v;
        tdcAddr = a;
        rdDone = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [14:0] expv, input logic [14:0] mask);
        logic [14:0] got;
        got = packOut(tdcReady, wrEn, wrBank, wrAddr, clrEn, clrBank, clrAddr,
                      rdReq, rdBank, activeBank, hisDone);
        compared++;
        if ((got & mask) !== (expv & mask)) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b, expected %b (mask %b)", tag, got, expv, mask);
        end
    endtask

    // Address/bank fields are only meaningful while their enable is expected high.
    task automatic expectOut(input string tag, input logic rdy, input logic we, input logic wb,
                             input logic [2:0] wa, input logic ce, input logic cb, input logic [2:0] ca,
                             input logic rq, input logic rb, input logic ab, input logic hd,
                             input logic all);
        logic [14:0] mask;
        mask = 15'h7fff;
        if (!all && !we) mask[12:9] = 4'b0000;
        if (!all && !ce) mask[7:4]  = 4'b0000;
        checkOutput(tag, packOut(rdy, we, wb, wa, ce, cb, ca, rq, rb, ab, hd), mask);
    endtask

    initial begin
        res = 1'b1;
        tdcValid = 1'b0;
        tdcAddr = 2'd0;
        rdDone = 1'b0;

        // Reset, clear of bank 0, fill of bank 0 with gaps, swap, clear of bank 1.
        //      res val adr dn  rdy we wb wa  ce cb ca  rq rb ab hd all
        addVec(1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 1);
        for (int a = 0; a < 8; a++)
            addVec(0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 3'(a), 0, 0, 0, 0, 0);
        addVec(0, 1, 3, 0,  1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
        addVec(0, 1, 3, 0,  1, 1, 0, 3,  0, 0, 0,  0, 0, 0, 0, 0);
        addVec(0, 1, 3, 0,  1, 1, 0, 3,  0, 0, 0,  0, 0, 0, 0, 0);
        addVec(0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
        addVec(0, 1, 1, 0,  1, 1, 0, 5,  0, 0, 0,  0, 0, 0, 0, 0);
        addVec(0, 1, 2, 0,  1, 1, 0, 6,  0, 0, 0,  0, 0, 0, 0, 0);
        addVec(0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
        addVec(0, 1, 0, 0,  1, 1, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
        addVec(0, 1, 3, 0,  1, 1, 0, 3,  0, 0, 0,  0, 0, 0, 0, 0);
        addVec(0, 1, 2, 0,  1, 1, 0, 6,  0, 0, 0,  0, 0, 0, 0, 0);
        addVec(0, 1, 1, 0,  0, 1, 0, 5,  0, 0, 0,  0, 0, 0, 1, 0);
        addVec(0, 1, 3, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
        addVec(0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 0,  1, 0, 1, 0, 0);
        for (int a = 1; a < 8; a++)
            addVec(0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 3'(a), 1, 0, 1, 0, 0);
        addVec(0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0,  1, 0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].res, vecs[i].valid, vecs[i].addr, vecs[i].rdDone);
            expectOut($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].wrEn, vecs[i].wrBank,
                      vecs[i].wrAddr, vecs[i].clrEn, vecs[i].clrBank, vecs[i].clrAddr,
                      vecs[i].rdReq, vecs[i].rdBank, vecs[i].act, vecs[i].his, vecs[i].chkAll);
        end

        // Fill bank 1 with tdc_valid held; the reader still owns bank 0.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 1, 3, 0);
            expectOut($sformatf("fill1_%0d", k), (k < 7), 1, 1, ((k % 4) < 2) ? 3'd3 : 3'd7,
                      0, 0, 0, 1, 0, 1, (k == 7), 0);
        end
        // No rd_done: scheduler must park in WAIT.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 3, 0);
            expectOut($sformatf("waitHold%0d", k), 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        end
        applyStimulus(0, 1, 3, 1);
        applyStimulus(0, 1, 3, 0);
        expectOut("swapToBank0", 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
        // Reader releases bank 1 partway through the clear of bank 0.
        for (int a = 1; a < 8; a++) begin
            applyStimulus(0, 1, 3, (a == 3));
            expectOut($sformatf("clear0_%0d", a), 0, 0, 0, 0, 1, 0, 3'(a), (a < 3), 1, 0, 0, 0);
        end
        applyStimulus(0, 1, 3, 0);
        expectOut("ready0", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        // Five samples into bank 0, then reset in the middle of the fill.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1, 1, 0);
            expectOut($sformatf("part%0d", k), 1, 1, 0, (k < 2 || k == 4) ? 3'd1 : 3'd5,
                      0, 0, 0, 0, 1, 0, 0, 0);
        end
        applyStimulus(1, 1, 1, 0);
        expectOut("midReset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Clear restarts at bank 0; a stray rd_done with no request is ignored.
        for (int a = 0; a < 8; a++) begin
            applyStimulus(0, 1, 1, (a == 4));
            expectOut($sformatf("reclear%0d", a), 0, 0, 0, 0, 1, 0, 3'(a), 0, 0, 0, 0, 0);
        end
        applyStimulus(0, 0, 0, 0);
        expectOut("ready1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 1, 2, 0);
            expectOut($sformatf("refill%0d", k), (k < 7), 1, 0, ((k % 4) < 2) ? 3'd2 : 3'd6,
                      0, 0, 0, 0, 0, 0, (k == 7), 0);
        end
        // Nothing pending, so WAIT passes straight to SWAP.
        applyStimulus(0, 0, 0, 0);
        expectOut("swapState", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        expectOut("swapToBank1", 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
